// File: rtl/seg7_pkg.sv
// Shared constants for the four-digit seven-segment display driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK           = 7'b1111111;
   localparam int         NUM_DIGITS          = 4;
   localparam int         REFRESH_DIV_DEFAULT = 25000;

   localparam logic [0:15][6:0] SEG_TABLE = '{
      7'b1000000,
      7'b1111001,
      7'b0100100,
      7'b0110000,
      7'b0011001,
      7'b0010010,
      7'b0000010,
      7'b1111000,
      7'b0000000,
      7'b0010000,
      7'b0001000,
      7'b0000011,
      7'b1000110,
      7'b0100001,
      7'b0000110,
      7'b0001110
   };

endpackage

// File: rtl/seg7_display_hex7seg.sv
// Hex nibble to active-low seven-segment pattern.
// Purely combinational lookup into the shared table.
module hex7seg
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seg7_display.sv
// Multiplexed four-digit hex display driver with leading-zero blanking.
// A frame latch keeps a whole refresh frame tear-free.
module seg7_display
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT,
   parameter bit BLANK_LZ    = 1'b1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] result,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        dp
);

   localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);

   logic [15:0] div_cnt;
   logic        tick;
   logic [1:0]  dig;
   logic [15:0] disp_val;
   logic [3:0]  nib;
   logic        blank;
   logic [6:0]  seg_dec;
   logic [6:0]  seg_nxt;
   logic [3:0]  an_nxt;

   assign tick = (div_cnt == DIV_LAST);

   // Slot timer: one tick per REFRESH_DIV cycles.
   always_ff @(posedge clk) begin
      if (reset)
         div_cnt <= '0;
      else if (tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 16'd1;
   end

   // Digit sequencer walks 0..3 once per tick.
   always_ff @(posedge clk) begin
      if (reset)
         dig <= '0;
      else if (tick)
         dig <= dig + 2'd1;
   end

   // Frame latch only updates at the end of digit 3 so a frame never tears.
   always_ff @(posedge clk) begin
      if (reset)
         disp_val <= '0;
      else if (tick && (dig == 2'd3))
         disp_val <= result;
   end

   // Select the active nibble and decide whether it is a leading zero.
   always_comb begin
      nib   = disp_val[3:0];
      blank = 1'b0;
      unique case (dig)
         2'd0: begin
            nib   = disp_val[3:0];
            blank = 1'b0;
         end
         2'd1: begin
            nib   = disp_val[7:4];
            blank = BLANK_LZ && (disp_val[15:4] == 12'h000);
         end
         2'd2: begin
            nib   = disp_val[11:8];
            blank = BLANK_LZ && (disp_val[15:8] == 8'h00);
         end
         2'd3: begin
            nib   = disp_val[15:12];
            blank = BLANK_LZ && (disp_val[15:12] == 4'h0);
         end
      endcase
   end

   hex7seg u_hex7seg (
      .nib (nib),
      .seg (seg_dec)
   );

   // Blanked slots keep every anode off rather than lighting an empty digit.
   always_comb begin
      an_nxt  = 4'b1111;
      seg_nxt = SEG_BLANK;
      if (!blank) begin
         an_nxt  = ~(4'b0001 << dig);
         seg_nxt = seg_dec;
      end
   end

   // Registered pin drivers so the anodes switch glitch-free.
   always_ff @(posedge clk) begin
      if (reset) begin
         seg <= SEG_BLANK;
         an  <= 4'b1111;
         dp  <= 1'b1;
      end else begin
         seg <= seg_nxt;
         an  <= an_nxt;
         dp  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg7_display.sv
// Bench for seg7_display: directed frames plus random result traffic.
// Two instances share stimulus, one with and one without zero blanking.
module tb_seg7_display;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] result = 16'h0000;
   logic [6:0]  seg1, seg0;
   logic [3:0]  an1, an0;
   logic        dp1, dp0;

   int vectors = 0;
   int miscompares = 0;

   logic [6:0] ref_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   int          m_n;
   logic [15:0] m_frame;
   logic [6:0]  e_seg1, e_seg0;
   logic [3:0]  e_an1, e_an0;

   logic [3:0]  prev_an0 = 4'hf;
   int          run = 0;

   seg7_display #(.REFRESH_DIV(D), .BLANK_LZ(1'b1)) dut (
      .clk    (clk),
      .reset  (reset),
      .result (result),
      .seg    (seg1),
      .an     (an1),
      .dp     (dp1)
   );

   seg7_display #(.REFRESH_DIV(D), .BLANK_LZ(1'b0)) dut0 (
      .clk    (clk),
      .reset  (reset),
      .result (result),
      .seg    (seg0),
      .an     (an0),
      .dp     (dp0)
   );

   always #5 clk = ~clk;

   function automatic int slot_of(int n);
      return (n / D) % 4;
   endfunction

   function automatic bit m_blank(int s, logic [15:0] v, bit blz);
      return blz && (s > 0) && ((v >> (4 * s)) == 16'h0000);
   endfunction

   function automatic logic [3:0] m_an(int s, logic [15:0] v, bit blz);
      logic [3:0] a;
      a = 4'hf;
      if (!m_blank(s, v, blz))
         a[s] = 1'b0;
      return a;
   endfunction

   function automatic logic [6:0] m_seg(int s, logic [15:0] v, bit blz);
      logic [15:0] d;
      if (m_blank(s, v, blz))
         return 7'h7f;
      d = (v >> (4 * s)) & 16'h000f;
      return ref_tab[d[3:0]];
   endfunction

   // Reference: slot and frame derived from cycles since reset release.
   always @(posedge clk) begin
      if (reset) begin
         m_n     <= 0;
         m_frame <= 16'h0000;
         e_seg1  <= 7'h7f;
         e_seg0  <= 7'h7f;
         e_an1   <= 4'hf;
         e_an0   <= 4'hf;
      end else begin
         e_seg1 <= m_seg(slot_of(m_n), m_frame, 1'b1);
         e_seg0 <= m_seg(slot_of(m_n), m_frame, 1'b0);
         e_an1  <= m_an(slot_of(m_n), m_frame, 1'b1);
         e_an0  <= m_an(slot_of(m_n), m_frame, 1'b0);
         m_n    <= m_n + 1;
         if (((m_n + 1) % (4 * D)) == 0)
            m_frame <= result;
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int k);
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         chk("seg_lz", 16'(seg1), 16'(e_seg1));
         chk("an_lz", 16'(an1), 16'(e_an1));
         chk("seg_nolz", 16'(seg0), 16'(e_seg0));
         chk("an_nolz", 16'(an0), 16'(e_an0));
         chk("dp_lz", 16'(dp1), 16'd1);
         chk("dp_nolz", 16'(dp0), 16'd1);
         chk("onehot_lz", 16'($countones(~an1) <= 1), 16'd1);
         chk("onehot_nolz", 16'($countones(~an0) <= 1), 16'd1);
         if (an0 !== prev_an0) begin
            if (prev_an0 != 4'hf && an0 != 4'hf)
               chk("slot_len", 16'(run), 16'(D));
            run      = 1;
            prev_an0 = an0;
         end else begin
            run++;
         end
      end
   endtask

   task automatic do_reset(input int k);
      reset = 1'b1;
      cyc(k);
      chk("rst_div", dut.div_cnt, 16'h0000);
      chk("rst_dig", 16'(dut.dig), 16'h0000);
      chk("rst_disp", dut.disp_val, 16'h0000);
      chk("rst_an", 16'(an1), 16'h000f);
      chk("rst_seg", 16'(seg1), 16'h007f);
      reset = 1'b0;
   endtask

   initial begin
      // 1234: frame load then digit walk 4,3,2,1
      do_reset(3);
      result = 16'h1234;
      cyc(16);
      chk("load_1234", dut.disp_val, 16'h1234);
      cyc(1);
      chk("f1_an0", 16'(an1), 16'b1110);
      chk("f1_seg0", 16'(seg1), 16'b0011001);
      cyc(4);
      chk("f1_an1", 16'(an1), 16'b1101);
      chk("f1_seg1", 16'(seg1), 16'b0110000);
      cyc(4);
      chk("f1_an2", 16'(an1), 16'b1011);
      chk("f1_seg2", 16'(seg1), 16'b0100100);
      cyc(4);
      chk("f1_an3", 16'(an1), 16'b0111);
      chk("f1_seg3", 16'(seg1), 16'b1111001);

      // 00A0: leading zeros blanked only with blanking on
      do_reset(3);
      result = 16'h00a0;
      cyc(17);
      chk("a0_an0", 16'(an1), 16'b1110);
      chk("a0_seg0", 16'(seg1), 16'b1000000);
      cyc(4);
      chk("a0_an1", 16'(an1), 16'b1101);
      chk("a0_seg1", 16'(seg1), 16'b0001000);
      cyc(4);
      chk("a0_an2", 16'(an1), 16'b1111);
      chk("a0_seg2", 16'(seg1), 16'b1111111);
      chk("a0_nolz_an2", 16'(an0), 16'b1011);
      chk("a0_nolz_seg2", 16'(seg0), 16'b1000000);
      cyc(4);
      chk("a0_an3", 16'(an1), 16'b1111);
      chk("a0_seg3", 16'(seg1), 16'b1111111);
      chk("a0_nolz_an3", 16'(an0), 16'b0111);
      chk("a0_nolz_seg3", 16'(seg0), 16'b1000000);

      // 0000: only digit 0 lit
      do_reset(3);
      result = 16'h0000;
      cyc(1);
      chk("z_an0", 16'(an1), 16'b1110);
      chk("z_seg0", 16'(seg1), 16'b1000000);
      cyc(4);
      chk("z_an1", 16'(an1), 16'b1111);
      chk("z_seg1", 16'(seg1), 16'b1111111);

      // FFFF -> 5555 mid-frame: no tearing; boundary edge capture
      do_reset(3);
      result = 16'hffff;
      cyc(16);
      cyc(5);
      chk("t_seg1", 16'(seg1), 16'b0001110);
      result = 16'h5555;
      cyc(4);
      chk("t_an2", 16'(an1), 16'b1011);
      chk("t_seg2", 16'(seg1), 16'b0001110);
      cyc(4);
      chk("t_an3", 16'(an1), 16'b0111);
      chk("t_seg3", 16'(seg1), 16'b0001110);
      cyc(4);
      chk("t_an0n", 16'(an1), 16'b1110);
      chk("t_seg0n", 16'(seg1), 16'b0010010);
      cyc(14);
      result = 16'h0789;
      cyc(1);
      chk("b_seg3", 16'(seg1), 16'b0010010);
      chk("b_disp", dut.disp_val, 16'h0789);
      cyc(1);
      chk("b_an0", 16'(an1), 16'b1110);
      chk("b_seg0", 16'(seg1), 16'b0010000);

      // Reset coinciding with a slot-2 tick
      do_reset(3);
      result = 16'h4321;
      cyc(16);
      chk("r_load", dut.disp_val, 16'h4321);
      cyc(11);
      chk("r_pre_dig", 16'(dut.dig), 16'd2);
      chk("r_pre_div", dut.div_cnt, 16'd3);
      reset = 1'b1;
      cyc(1);
      chk("r_an", 16'(an1), 16'b1111);
      chk("r_seg", 16'(seg1), 16'b1111111);
      chk("r_dig", 16'(dut.dig), 16'd0);
      chk("r_disp", dut.disp_val, 16'h0000);
      chk("r_div", dut.div_cnt, 16'h0000);
      reset = 1'b0;
      cyc(1);
      chk("r_rel_an", 16'(an1), 16'b1110);
      chk("r_rel_seg", 16'(seg1), 16'b1000000);
      cyc(4);
      chk("r_tick_an", 16'(an0), 16'b1101);

      // Random result traffic with occasional resets
      do_reset(2);
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 2) == 0)
            result = 16'($urandom) >> (4 * $urandom_range(0, 4));
         reset = ($urandom_range(0, 156) == 0);
         cyc(1);
      end
      reset = 1'b0;
      cyc(20);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seg7_display.md
SEG7_DISPLAY -- requirements
Module: seg7_display

Interface
REQ-001 Parameter REFRESH_DIV, default 25000: clk cycles per digit slot (1 kHz digit rate at 25 MHz); legal range 2..65535.
REQ-002 Parameter BLANK_LZ, default 1: 1 enables leading-zero blanking, 0 always drives all four digits.
REQ-003 clk  input  1  system clock (the divided 25 MHz clock that also drives the CPU and memory); all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled only on the rising edge of clk.
REQ-005 result  input  16  value produced by the data memory; consumed as four hex nibbles; may change on any cycle.
REQ-006 seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-007 an  output  4  digit anode enables, active-low, one-hot or all-high; an[0] is the rightmost digit (result[3:0]).
REQ-008 dp  output  1  decimal point, active-low; held at 1 (off).

Function
REQ-009 A divider counter div_cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick SHALL be asserted in the cycle where div_cnt == REFRESH_DIV-1.
REQ-010 A digit index dig (2 bits) SHALL advance by 1 on each tick and wrap 3 -> 0.
REQ-011 A frame register disp_val (16 bits) SHALL load result only on a tick with dig == 3 (frame boundary); result changes at any other time SHALL NOT affect the current frame (no tearing).
REQ-012 seg, an and dp SHALL be registered; they SHALL reflect the current dig and disp_val one clk after either changes.
REQ-013 For the active digit k: an = 4'b1111 with bit k cleared; seg = decode(disp_val[4k+3:4k]).
REQ-014 Decode (active-low) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-015 With BLANK_LZ=1, digit k>0 SHALL be blanked (an = 4'b1111, seg = 1111111) when disp_val[15:4k] == 0; digit 0 SHALL never be blanked (value 0 shows a single "0").
REQ-016 With BLANK_LZ=0, no digit SHALL be blanked.
REQ-017 Digit slot length SHALL be exactly REFRESH_DIV cycles; full frame 4*REFRESH_DIV cycles; no gaps or double-enabled anodes at any transition.
REQ-018 result transitions coinciding with the frame-boundary tick SHALL be captured (the value present on that edge).

Reset
REQ-019 On reset: div_cnt=0, dig=0, disp_val=16'h0000, seg=7'b1111111, an=4'b1111, dp=1.
REQ-020 Reset asserted mid-slot or mid-frame SHALL take effect on the next rising edge, overriding any tick in that cycle.
REQ-021 After reset deasserts, the first tick SHALL occur REFRESH_DIV cycles later; digit 0 shows the reset disp_val (0) until the first frame boundary; outputs SHALL drive digit 0 from the first cycle after reset release.

Structure
REQ-022 Package seg7_pkg SHALL hold SEG_BLANK (7'b1111111), NUM_DIGITS (4), REFRESH_DIV_DEFAULT (25000) and the 16-entry decode table constant.
REQ-023 One sub-module hex7seg (4-bit nibble in, 7-bit active-low segments out, combinational) SHALL implement REQ-014; the divider, digit sequencer, frame latch, blanking and output registers remain in seg7_display.

Verification (REFRESH_DIV=4, BLANK_LZ=1 unless stated)
REQ-024 Reset 3 cycles, release, result=16'h1234 -> at first frame boundary (16 cycles) disp_val=1234; following frame: an cycles 1110,1101,1011,0111 every 4 cycles with seg 0011001,0110000,0100100,1111001 (4,3,2,1 for an[0..3]).
REQ-025 result=16'h00A0 -> an[3], an[2] held 1, seg=1111111 in those slots; slot 1 shows 0001000, slot 0 shows 1000000; with BLANK_LZ=0 slots 3,2 show 1000000.
REQ-026 result=16'h0000 -> only digit 0 enabled, seg=1000000; dp=1 throughout.
REQ-027 result changes 16'hFFFF -> 16'h5555 during slot 1 -> remaining slots of that frame show F (0001110); 5 (0010010) appears only after next frame boundary; change applied on the boundary edge itself is captured.
REQ-028 Reset asserted during slot 2 coincident with a tick -> next edge: an=1111, seg=1111111, dig=0, disp_val=0; assertion checks: an never has more than one bit low; each slot exactly 4 cycles.
